// File: rtl/uart_i2c_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART-to-I2C command sequencer.
package uart_i2c_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StReply = 3'd4
  } state_e;

  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_s = 8'h73;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_O = 8'h4F;

  // Returns {valid, nibble}; letters of either case map to 10..15.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart_tx_queue.sv
// Four-deep reply FIFO that paces characters into the UART transmitter.
module uart_tx_queue (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start
);

  logic [7:0] mem_q [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] cnt_q;
  logic [7:0] data_q;
  logic       start_q;
  logic       pop, wr;

  assign full = (cnt_q == 3'd4);
  // Skipping the cycle right after a start hides the transmitter's busy latency.
  assign pop  = (cnt_q != 3'd0) && !tx_busy && !start_q;
  assign wr   = push && !full;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      cnt_q   <= 3'd0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
    end else begin
      start_q <= pop;
      if (pop) begin
        data_q <= mem_q[rptr_q];
        rptr_q <= rptr_q + 2'd1;
      end
      if (wr) begin
        wptr_q <= wptr_q + 2'd1;
      end
      cnt_q <= cnt_q + {2'b00, wr} - {2'b00, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (wr) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign tx_data  = data_q;
  assign tx_start = start_q;

endmodule

// File: rtl/uart_i2c_sequencer.sv
// Parses "S <hh W|R>... s" frames from the UART, buffers the entries and replays them as
// byte transfers on an I2C master, answering over UART with status and read data.
module uart_i2c_sequencer
  import uart_i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic          i2c_start,
  output logic          i2c_stop,
  output logic          i2c_rw,
  output logic [7:0]    i2c_wdata,
  output logic          i2c_go,
  input  logic          i2c_ack,
  input  logic          i2c_nack,
  input  logic          i2c_to,
  input  logic [7:0]    i2c_rdata,
  output logic [2:0]    state,
  output logic [AW:0]   count
);

  localparam logic [AW:0] CntOne   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  state_e      state_q, state_d, ret_q, ret_d;
  logic [AW:0] count_q, count_d, idx_q, idx_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  byte_q, byte_d;
  logic        nib_pend_q, nib_pend_d, byte_ok_q, byte_ok_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [1:0]  rlen_q, rlen_d;
  logic [8:0]  buf_q [DEPTH];
  logic [8:0]  rd_entry;
  logic [4:0]  nib;
  logic        buf_we, push, q_full, rep_en, active, last;
  logic [7:0]  rep_ch;

  assign nib      = hex2nib(rx_data);
  assign rd_entry = buf_q[idx_q[AW-1:0]];
  assign last     = (idx_q + CntOne) == count_q;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    count_d    = count_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    byte_d     = byte_q;
    nib_pend_d = nib_pend_q;
    byte_ok_d  = byte_ok_q;
    rbuf_d     = rbuf_q;
    rlen_d     = rlen_q;
    buf_we     = 1'b0;
    push       = 1'b0;
    rep_en     = 1'b0;
    rep_ch     = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == CH_S) begin
          state_d    = StFill;
          count_d    = '0;
          nib_pend_d = 1'b0;
          byte_ok_d  = 1'b0;
        end
      end
      StFill: begin
        if (rx_valid) begin
          if (rx_data == CH_S) begin
            count_d    = '0;
            nib_pend_d = 1'b0;
            byte_ok_d  = 1'b0;
          end else if (nib[4]) begin
            if (byte_ok_q) begin
              rep_en = 1'b1;
              rep_ch = CH_E;
            end else if (!nib_pend_q) begin
              hi_d       = nib[3:0];
              nib_pend_d = 1'b1;
            end else begin
              byte_d     = {hi_q, nib[3:0]};
              nib_pend_d = 1'b0;
              byte_ok_d  = 1'b1;
            end
          end else if (rx_data == CH_W || rx_data == CH_R) begin
            if (!byte_ok_q) begin
              rep_en = 1'b1;
              rep_ch = CH_E;
            end else if (count_q == DepthCnt) begin
              rep_en = 1'b1;
              rep_ch = CH_O;
            end else begin
              buf_we    = 1'b1;
              count_d   = count_q + CntOne;
              byte_ok_d = 1'b0;
            end
          end else if (rx_data == CH_s) begin
            if (nib_pend_q || byte_ok_q) begin
              rep_en = 1'b1;
              rep_ch = CH_E;
            end else if (count_q == '0) begin
              rep_en = 1'b1;
              rep_ch = CH_D;
            end else begin
              state_d = StIssue;
              idx_d   = '0;
            end
          end else begin
            rep_en = 1'b1;
            rep_ch = CH_E;
          end
        end
      end
      // At most one transfer is ever outstanding, so the master is free whenever we get here.
      StIssue: state_d = StWait;
      StWait: begin
        if (i2c_nack) begin
          rep_en = 1'b1;
          rep_ch = CH_N;
        end else if (i2c_to) begin
          rep_en = 1'b1;
          rep_ch = CH_T;
        end else if (i2c_ack) begin
          idx_d = idx_q + CntOne;
          if (rd_entry[8]) begin
            rbuf_d  = {nib2hex(i2c_rdata[7:4]), nib2hex(i2c_rdata[3:0]), CH_D};
            rlen_d  = last ? 2'd3 : 2'd2;
            ret_d   = last ? StIdle : StIssue;
            state_d = StReply;
          end else if (last) begin
            rep_en = 1'b1;
            rep_ch = CH_D;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StReply: begin
        if (rlen_q != 2'd0) begin
          if (!q_full) begin
            push   = 1'b1;
            rbuf_d = {rbuf_q[15:0], 8'h00};
            rlen_d = rlen_q - 2'd1;
          end
        end else begin
          state_d = ret_q;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rep_en) begin
      state_d = StReply;
      ret_d   = StIdle;
      rbuf_d  = {rep_ch, 16'h0000};
      rlen_d  = 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      ret_q      <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      hi_q       <= 4'h0;
      byte_q     <= 8'h00;
      nib_pend_q <= 1'b0;
      byte_ok_q  <= 1'b0;
      rbuf_q     <= 24'h0;
      rlen_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      byte_q     <= byte_d;
      nib_pend_q <= nib_pend_d;
      byte_ok_q  <= byte_ok_d;
      rbuf_q     <= rbuf_d;
      rlen_q     <= rlen_d;
    end
  end

  always_ff @(posedge clock) begin
    if (buf_we) begin
      buf_q[count_q[AW-1:0]] <= {rx_data == CH_R, byte_q};
    end
  end

  uart_tx_queue u_tx_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (rbuf_q[23:16]),
    .full      (q_full),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start)
  );

  assign active    = (state_q == StIssue) || (state_q == StWait);
  assign i2c_go    = (state_q == StIssue);
  assign i2c_start = active && (idx_q == '0);
  assign i2c_stop  = active && (idx_q == count_q - CntOne);
  assign i2c_rw    = active && rd_entry[8];
  assign i2c_wdata = active ? rd_entry[7:0] : 8'h00;
  assign state     = state_q;
  assign count     = count_q;

endmodule

// File: tb/tb_uart_i2c_sequencer.sv
// Scoreboard bench: frames and expected I2C/UART traffic are planned together; monitors
// compare the DUT's transfers and reply characters against the queued expectations.
module tb_uart_i2c_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  localparam logic [7:0] K_S = 8'h53, K_s = 8'h73, K_W = 8'h57, K_R = 8'h52, K_D = 8'h44;
  localparam logic [7:0] K_N = 8'h4E, K_T = 8'h54, K_E = 8'h45, K_O = 8'h4F;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       rw;
    logic [7:0] data;
  } xfer_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy = 1'b0;
  logic i2c_start, i2c_stop, i2c_rw, i2c_go;
  logic [7:0] i2c_wdata;
  logic i2c_ack = 1'b0, i2c_nack = 1'b0, i2c_to = 1'b0;
  logic [7:0] i2c_rdata = 8'h00;
  logic [2:0] state;
  logic [AW:0] count;

  xfer_t      exp_x[$];
  logic [7:0] exp_c[$];
  int         resp_kind[$];   // 0 ack, 1 nack, 2 timeout, 3 never answer
  logic [7:0] resp_data[$];
  logic [7:0] fr[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  uart_i2c_sequencer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .i2c_start (i2c_start),
    .i2c_stop  (i2c_stop),
    .i2c_rw    (i2c_rw),
    .i2c_wdata (i2c_wdata),
    .i2c_go    (i2c_go),
    .i2c_ack   (i2c_ack),
    .i2c_nack  (i2c_nack),
    .i2c_to    (i2c_to),
    .i2c_rdata (i2c_rdata),
    .state     (state),
    .count     (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input logic lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  // Transfer and UART monitor, plus the transmitter's busy behaviour.
  int busy_cnt = 0;
  always @(negedge clock) begin
    xfer_t e;
    logic [7:0] c;
    if (reset) begin
      busy_cnt = 0;
      tx_busy  = 1'b0;
    end else begin
      if (i2c_go) begin
        if (exp_x.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_i2c_go: got data 0x%0h, required no transfer", i2c_wdata);
        end else begin
          e = exp_x.pop_front();
          check("i2c_xfer{start,stop,rw,data}", {21'b0, i2c_start, i2c_stop, i2c_rw, i2c_wdata},
                {21'b0, e});
        end
      end
      if (tx_start) begin
        check("tx_start_while_busy", {31'b0, tx_busy}, 32'd0);
        if (exp_c.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_tx_char: got 0x%0h, required none", tx_data);
        end else begin
          c = exp_c.pop_front();
          check("tx_char", {24'b0, tx_data}, {24'b0, c});
        end
      end
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start) busy_cnt = $urandom_range(1, 4);
      tx_busy = (busy_cnt > 0);
    end
  end

  // I2C master model: answers each go after a short random delay using the planned response.
  logic slv_busy = 1'b0;
  int   slv_cnt  = 0;
  int   slv_kind = 0;
  always @(negedge clock) begin
    i2c_ack  = 1'b0;
    i2c_nack = 1'b0;
    i2c_to   = 1'b0;
    if (reset) begin
      slv_busy = 1'b0;
    end else if (slv_busy) begin
      if (slv_cnt == 0) begin
        slv_busy = 1'b0;
        case (slv_kind)
          0: i2c_ack = 1'b1;
          1: i2c_nack = 1'b1;
          2: i2c_to = 1'b1;
          default: slv_busy = 1'b1;
        endcase
      end else begin
        slv_cnt--;
      end
    end else if (i2c_go) begin
      slv_busy = 1'b1;
      slv_cnt  = $urandom_range(0, 3);
      if (resp_kind.size() > 0) begin
        slv_kind  = resp_kind.pop_front();
        i2c_rdata = resp_data.pop_front();
      end else begin
        slv_kind  = 0;
        i2c_rdata = 8'h00;
      end
    end
  end

  task automatic add_entry(input logic [7:0] d, input logic rw);
    fr.push_back(hexc(d[7:4], $urandom_range(0, 1) == 1));
    fr.push_back(hexc(d[3:0], $urandom_range(0, 1) == 1));
    fr.push_back(rw ? K_R : K_W);
  endtask

  task automatic expect_x(input logic s, input logic p, input logic rw, input logic [7:0] d);
    xfer_t x;
    x.start = s; x.stop = p; x.rw = rw; x.data = d;
    exp_x.push_back(x);
  endtask

  task automatic resp(input int k, input logic [7:0] rd);
    resp_kind.push_back(k);
    resp_data.push_back(rd);
  endtask

  task automatic send_frame();
    while (fr.size() > 0) begin
      @(posedge clock); #1;
      rx_data  = fr.pop_front();
      rx_valid = 1'b1;
      @(posedge clock); #1;
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (t < 2000 && !(exp_x.size() == 0 && exp_c.size() == 0 && state == 3'd0));
    check({name, "_state_idle"}, {29'b0, state}, 32'd0);
    check({name, "_pending_xfers"}, exp_x.size(), 32'd0);
    check({name, "_pending_chars"}, exp_c.size(), 32'd0);
    exp_x.delete(); exp_c.delete(); resp_kind.delete(); resp_data.delete();
    repeat (3) @(negedge clock);
  endtask

  // Random frame of one of four shapes; expectations come from the frame contents directly.
  task automatic random_frame(input int iter);
    int shape, n, k, nbad;
    logic [7:0] d;
    logic rw, stopped;
    shape = $urandom_range(0, 9);
    n = $urandom_range(1, DEPTH);
    if ($urandom_range(0, 3) == 0) fr.push_back(8'h78);
    if ($urandom_range(0, 3) == 0) begin
      fr.push_back(K_S);
      add_entry(8'h7E, 1'b1);
      fr.push_back(8'h31);
    end
    fr.push_back(K_S);
    if (shape == 0) begin
      nbad = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < nbad; i++) add_entry(8'($urandom), 1'($urandom_range(0, 1)));
      case ($urandom_range(0, 4))
        0: fr.push_back(8'h67);
        1: begin fr.push_back(8'h35); fr.push_back(8'h67); end
        2: fr.push_back(K_W);
        3: begin fr.push_back(8'h31); fr.push_back(K_s); end
        default: begin fr.push_back(8'h31); fr.push_back(8'h32); fr.push_back(8'h33); end
      endcase
      exp_c.push_back(K_E);
      send_frame();
      wait_idle("rand_bad");
    end else if (shape == 1) begin
      for (int i = 0; i <= DEPTH; i++) add_entry(8'($urandom), 1'($urandom_range(0, 1)));
      exp_c.push_back(K_O);
      send_frame();
      wait_idle("rand_ovf");
      check("rand_ovf_count", {29'b0, count}, DEPTH);
    end else if (shape == 2) begin
      fr.push_back(K_s);
      exp_c.push_back(K_D);
      send_frame();
      wait_idle("rand_empty");
    end else begin
      stopped = 1'b0;
      for (int i = 0; i < n; i++) begin
        d  = 8'($urandom);
        rw = 1'($urandom_range(0, 1));
        add_entry(d, rw);
        if (!stopped) begin
          expect_x(i == 0, i == n - 1, rw, d);
          k = $urandom_range(0, 9);
          k = (k == 0) ? 1 : (k == 1) ? 2 : 0;
          resp(k, 8'($urandom));
          if (k == 1) begin
            exp_c.push_back(K_N); stopped = 1'b1;
          end else if (k == 2) begin
            exp_c.push_back(K_T); stopped = 1'b1;
          end else begin
            if (rw) begin
              exp_c.push_back(hexc(resp_data[resp_data.size()-1][7:4], 1'b0));
              exp_c.push_back(hexc(resp_data[resp_data.size()-1][3:0], 1'b0));
            end
            if (i == n - 1) exp_c.push_back(K_D);
          end
        end
      end
      fr.push_back(K_s);
      send_frame();
      wait_idle($sformatf("rand_frame%0d", iter));
      check("rand_count", {29'b0, count}, n);
    end
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_state", {29'b0, state}, 32'd0);
    check("reset_count", {29'b0, count}, 32'd0);
    check("reset_outputs", {20'b0, tx_start, i2c_go, i2c_start, i2c_stop, i2c_rw, tx_data[6:0]},
          32'd0);

    // Two writes, all acked.
    fr.push_back(K_S); add_entry(8'h50, 1'b0); add_entry(8'hA3, 1'b0); fr.push_back(K_s);
    expect_x(1, 0, 0, 8'h50); expect_x(0, 1, 0, 8'hA3);
    resp(0, 8'h00); resp(0, 8'h00);
    exp_c.push_back(K_D);
    send_frame(); wait_idle("two_writes");
    check("two_writes_count", {29'b0, count}, 32'd2);

    // Single read returns hex of the data then D.
    fr.push_back(K_S); add_entry(8'h51, 1'b1); fr.push_back(K_s);
    expect_x(1, 1, 1, 8'h51); resp(0, 8'h3C);
    exp_c.push_back(8'h33); exp_c.push_back(8'h43); exp_c.push_back(K_D);
    send_frame(); wait_idle("single_read");

    // Nack on second byte.
    fr.push_back(K_S); add_entry(8'h50, 1'b0); add_entry(8'h12, 1'b0); fr.push_back(K_s);
    expect_x(1, 0, 0, 8'h50); expect_x(0, 1, 0, 8'h12);
    resp(0, 8'h00); resp(1, 8'h00);
    exp_c.push_back(K_N);
    send_frame(); wait_idle("nack");

    // Overflow at DEPTH+1 entries.
    fr.push_back(K_S);
    for (int i = 0; i <= DEPTH; i++) add_entry(8'h00, 1'b0);
    exp_c.push_back(K_O);
    send_frame(); wait_idle("overflow");
    check("overflow_count", {29'b0, count}, DEPTH);

    // Bad hex digit; the trailing W lands while replying or idle and is ignored.
    fr.push_back(K_S); fr.push_back(8'h35); fr.push_back(8'h67); fr.push_back(K_W);
    exp_c.push_back(K_E);
    send_frame(); wait_idle("bad_char");

    fr.push_back(K_S); fr.push_back(K_s);
    exp_c.push_back(K_D);
    send_frame(); wait_idle("empty_frame");

    fr.push_back(K_S); add_entry(8'h60, 1'b0); fr.push_back(K_s);
    expect_x(1, 1, 0, 8'h60); resp(2, 8'h00);
    exp_c.push_back(K_T);
    send_frame(); wait_idle("timeout");

    // Reset while waiting on a transfer that never completes.
    fr.push_back(K_S); add_entry(8'h42, 1'b1); fr.push_back(K_s);
    expect_x(1, 1, 1, 8'h42); resp(3, 8'h00);
    send_frame();
    t = 0;
    while (state != 3'd3 && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("reached_wait", {29'b0, state}, 32'd3);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("reset_mid_state", {29'b0, state}, 32'd0);
    check("reset_mid_count", {29'b0, count}, 32'd0);
    check("reset_mid_outputs", {15'b0, tx_start, i2c_go, i2c_start, i2c_stop, i2c_rw,
          i2c_wdata, tx_data[3:0]}, 32'd0);
    check("reset_mid_tx_data", {24'b0, tx_data}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    wait_idle("after_reset");

    fr.push_back(K_S); add_entry(8'h50, 1'b0); add_entry(8'hA3, 1'b1); fr.push_back(K_s);
    expect_x(1, 0, 0, 8'h50); expect_x(0, 1, 1, 8'hA3);
    resp(0, 8'h00); resp(0, 8'hE7);
    exp_c.push_back(8'h45); exp_c.push_back(8'h37); exp_c.push_back(K_D);
    send_frame(); wait_idle("post_reset_frame");

    for (int i = 0; i < 40; i++) random_frame(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
